// File: rtl/norm_pkg.sv
// ============================================================================
// Module   : norm_pkg
// Desc     : Shared widths, flag-bit indices and rounded-result type for the
//            normalize/round/pack datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package norm_pkg;

    localparam int DEF_A_WIDTH   = 8;
    localparam int DEF_EXP_WIDTH = 4;
    localparam int DEF_M_WIDTH   = 5;

    localparam int FLG_ZERO    = 0;
    localparam int FLG_INEXACT = 1;
    localparam int FLG_OVFL    = 2;
    localparam int FLG_W       = 3;

    typedef struct packed {
        logic [DEF_M_WIDTH-1:0]   mant;
        logic [DEF_EXP_WIDTH-1:0] exp;
        logic                     zero;
        logic                     inexact;
        logic                     ovfl;
    } rnd_res_t;

    function automatic logic [FLG_W-1:0] flags_of(input rnd_res_t r);
        logic [FLG_W-1:0] f;
        f              = '0;
        f[FLG_ZERO]    = r.zero;
        f[FLG_INEXACT] = r.inexact;
        f[FLG_OVFL]    = r.ovfl;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rnd_ne.sv
// ============================================================================
// Module   : rnd_ne
// Desc     : Combinational round-to-nearest-even with carry renormalization,
//            exponent saturation and zero handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rnd_ne
    import norm_pkg::*;
(
    input  logic [DEF_M_WIDTH-1:0]   kept_i,
    input  logic                     guard_i,
    input  logic                     sticky_i,
    input  logic [DEF_EXP_WIDTH-1:0] exp_i,
    input  logic                     no_detect_i,
    input  logic                     ovfl_i,
    output rnd_res_t                 res_o
);

    localparam logic [DEF_EXP_WIDTH-1:0] EXP_ONE  = {{(DEF_EXP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DEF_EXP_WIDTH-1:0] EXP_MAX  = '1;
    localparam logic [DEF_M_WIDTH-1:0]   MANT_MAX = '1;
    localparam logic [DEF_M_WIDTH-1:0]   MANT_MSB = {1'b1, {(DEF_M_WIDTH-1){1'b0}}};

    logic                 rnd_up;
    logic                 inexact;
    logic [DEF_M_WIDTH:0] sum;
    logic                 carry;
    logic                 carry_ovfl;

    // Exact ties round up only when the kept LSB is odd.
    assign rnd_up     = guard_i & (sticky_i | kept_i[0]);
    assign inexact    = guard_i | sticky_i;
    assign sum        = {1'b0, kept_i} + {{DEF_M_WIDTH{1'b0}}, rnd_up};
    assign carry      = sum[DEF_M_WIDTH];
    assign carry_ovfl = carry && (exp_i == EXP_MAX);

    always_comb begin
        res_o = '0;
        if (no_detect_i) begin
            res_o.zero = 1'b1;
        end else if (ovfl_i || carry_ovfl) begin
            res_o.mant    = MANT_MAX;
            res_o.exp     = EXP_MAX;
            res_o.ovfl    = 1'b1;
            res_o.inexact = 1'b1;
        end else if (carry) begin
            // A carry out only happens from all-ones, so the result is exactly 1.000...
            res_o.mant    = MANT_MSB;
            res_o.exp     = exp_i + EXP_ONE;
            res_o.inexact = inexact;
        end else begin
            res_o.mant    = sum[DEF_M_WIDTH-1:0];
            res_o.exp     = exp_i;
            res_o.inexact = inexact;
        end
    end

endmodule

`default_nettype wire

// File: rtl/norm_round_pack.sv
// ============================================================================
// Module   : norm_round_pack
// Desc     : Two-stage valid/ready pipeline that rounds a normalized mantissa
//            (RNE), renormalizes, saturates and packs the result.
//            Optional sticky result flags: define NORM_ROUND_STICKY_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module norm_round_pack
    import norm_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int M_WIDTH   = DEF_M_WIDTH
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_mant,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic                 in_no_detect,
    input  logic                 in_ovfl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M_WIDTH-1:0]   out_mant,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_zero,
    output logic                 out_inexact,
    output logic                 out_ovfl
`ifdef NORM_ROUND_STICKY_FLAGS_EN
    ,
    input  logic                 flags_clr,
    output logic [FLG_W-1:0]     sticky_flags
`endif
);

    localparam int GUARD_IDX = A_WIDTH - M_WIDTH - 1;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load;
    logic s2_load;

    assign in_ready   = !s1_valid_q || !s2_valid_q || out_ready;
    assign s1_load    = in_valid && in_ready;
    assign s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
    assign s1_valid_d = s1_load || (s1_valid_q && !s2_load);
    assign s2_valid_d = s2_load || (s2_valid_q && !out_ready);

    // ------------------------------------------------------------------
    // Stage 1: split mantissa into kept / guard / sticky
    // ------------------------------------------------------------------
    logic [M_WIDTH-1:0]   s1_kept_q,   s1_kept_d;
    logic                 s1_guard_q,  s1_guard_d;
    logic                 s1_sticky_q, s1_sticky_d;
    logic [EXP_WIDTH-1:0] s1_exp_q,    s1_exp_d;
    logic                 s1_nd_q,     s1_nd_d;
    logic                 s1_ovfl_q,   s1_ovfl_d;

    always_comb begin
        s1_kept_d   = s1_kept_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_exp_d    = s1_exp_q;
        s1_nd_d     = s1_nd_q;
        s1_ovfl_d   = s1_ovfl_q;
        if (s1_load) begin
            s1_kept_d   = in_mant[A_WIDTH-1 -: M_WIDTH];
            s1_guard_d  = in_mant[GUARD_IDX];
            s1_sticky_d = |in_mant[GUARD_IDX-1:0];
            s1_exp_d    = in_exp;
            s1_nd_d     = in_no_detect;
            s1_ovfl_d   = in_ovfl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_kept_q   <= '0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= '0;
            s1_nd_q     <= 1'b0;
            s1_ovfl_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_kept_q   <= s1_kept_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_exp_q    <= s1_exp_d;
            s1_nd_q     <= s1_nd_d;
            s1_ovfl_q   <= s1_ovfl_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and register the packed result
    // ------------------------------------------------------------------
    rnd_res_t rnd_res;
    rnd_res_t s2_res_q, s2_res_d;

    rnd_ne u_rnd_ne (
        .kept_i      (s1_kept_q),
        .guard_i     (s1_guard_q),
        .sticky_i    (s1_sticky_q),
        .exp_i       (s1_exp_q),
        .no_detect_i (s1_nd_q),
        .ovfl_i      (s1_ovfl_q),
        .res_o       (rnd_res)
    );

    // Holding s2 when not loading keeps outputs frozen under backpressure.
    assign s2_res_d = s2_load ? rnd_res : s2_res_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_mant    = s2_res_q.mant;
    assign out_exp     = s2_res_q.exp;
    assign out_zero    = s2_res_q.zero;
    assign out_inexact = s2_res_q.inexact;
    assign out_ovfl    = s2_res_q.ovfl;

`ifdef NORM_ROUND_STICKY_FLAGS_EN
    // ------------------------------------------------------------------
    // Accumulated result flags; a same-edge handshake wins over the clear
    // ------------------------------------------------------------------
    logic [FLG_W-1:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = flags_clr ? '0 : sticky_q;
        if (s2_valid_q && out_ready) begin
            sticky_d = sticky_d | flags_of(s2_res_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

`default_nettype wire
